// File: rtl/multi_channel_step_counter.sv
// Bank of independent step counters sharing one clock. MODE selects wrap,
// saturate or bounce (triangle) behaviour for every lane.
module multi_channel_step_counter #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  parameter int STEP     = 1,
  parameter int LIMIT    = 255,
  parameter int MODE     = 0
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [CHANNELS-1:0]       i_en,
  input  logic [CHANNELS-1:0]       i_clr,
  output logic [CHANNELS*WIDTH-1:0] o_cnt,
  output logic [CHANNELS-1:0]       o_tick,
  output logic [CHANNELS-1:0]       o_done,
  output logic                      o_tick_any
);

  if (MODE < 0 || MODE > 2) begin : g_bad_mode
    $error("multi_channel_step_counter: MODE must be 0, 1 or 2");
  end
  if (CHANNELS < 1 || WIDTH < 2 || STEP < 1 || STEP > LIMIT || LIMIT > (2**WIDTH) - 1) begin : g_bad_size
    $error("multi_channel_step_counter: illegal CHANNELS/WIDTH/STEP/LIMIT");
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        cnt_q  <= '0;
        tick_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        tick_q <= tick_d;
      end
    end

    assign o_cnt[k*WIDTH +: WIDTH] = cnt_q;
    assign o_tick[k]               = tick_q;

    if (MODE == 0) begin : g_wrap
      localparam logic [WIDTH:0] STEP_X  = (WIDTH+1)'(STEP);
      localparam logic [WIDTH:0] LIMIT_X = (WIDTH+1)'(LIMIT);
      logic [WIDTH:0] sum;

      // Sum is one bit wider so cnt+STEP cannot wrap before the compare.
      always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        sum    = {1'b0, cnt_q} + STEP_X;
        if (i_clr[k]) begin
          cnt_d = '0;
        end else if (i_en[k]) begin
          if (sum > LIMIT_X) begin
            cnt_d  = '0;
            tick_d = 1'b1;
          end else begin
            cnt_d = sum[WIDTH-1:0];
          end
        end
      end

      assign o_done[k] = 1'b0;
    end else if (MODE == 1) begin : g_sat
      localparam logic [WIDTH:0]   STEP_X  = (WIDTH+1)'(STEP);
      localparam logic [WIDTH:0]   LIMIT_X = (WIDTH+1)'(LIMIT);
      localparam logic [WIDTH-1:0] LIMIT_W = WIDTH'(LIMIT);
      logic [WIDTH:0] sum;

      always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        sum    = {1'b0, cnt_q} + STEP_X;
        if (i_clr[k]) begin
          cnt_d = '0;
        end else if (i_en[k] && cnt_q != LIMIT_W) begin
          if (sum >= LIMIT_X) begin
            cnt_d  = LIMIT_W;
            tick_d = 1'b1;
          end else begin
            cnt_d = sum[WIDTH-1:0];
          end
        end
      end

      assign o_done[k] = (cnt_q == LIMIT_W);
    end else begin : g_bounce
      localparam logic [WIDTH:0]   STEP_X  = (WIDTH+1)'(STEP);
      localparam logic [WIDTH:0]   LIMIT_X = (WIDTH+1)'(LIMIT);
      localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
      localparam logic [WIDTH-1:0] LIMIT_W = WIDTH'(LIMIT);
      typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;
      dir_e           dir_q, dir_d;
      logic [WIDTH:0] sum;

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) dir_q <= DIR_UP;
        else       dir_q <= dir_d;
      end

      // Down-count tests cnt <= STEP before subtracting so it never underflows.
      always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        dir_d  = dir_q;
        sum    = {1'b0, cnt_q} + STEP_X;
        if (i_clr[k]) begin
          cnt_d = '0;
          dir_d = DIR_UP;
        end else if (i_en[k]) begin
          if (dir_q == DIR_UP) begin
            if (sum >= LIMIT_X) begin
              cnt_d  = LIMIT_W;
              dir_d  = DIR_DOWN;
              tick_d = 1'b1;
            end else begin
              cnt_d = sum[WIDTH-1:0];
            end
          end else if ({1'b0, cnt_q} <= STEP_X) begin
            cnt_d  = '0;
            dir_d  = DIR_UP;
            tick_d = 1'b1;
          end else begin
            cnt_d = cnt_q - STEP_W;
          end
        end
      end

      assign o_done[k] = (cnt_q == LIMIT_W);
    end
  end

  assign o_tick_any = |o_tick;

endmodule

// File: tb/tb_multi_channel_step_counter.sv
// Bench for multi_channel_step_counter: four instances (wrap, saturate, bounce,
// wide-step wrap) checked against a queue of expected per-lane outputs.
module tb_multi_channel_step_counter;
  localparam int CH = 4;
  localparam int W  = 8;
  localparam int ND = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [CH-1:0]   en   [ND];
  logic [CH-1:0]   clr  [ND];
  logic [CH*W-1:0] cnt  [ND];
  logic [CH-1:0]   tick [ND];
  logic [CH-1:0]   done [ND];
  logic            tany [ND];

  always #5 clk = ~clk;

  multi_channel_step_counter #(.CHANNELS(CH), .WIDTH(W), .STEP(3), .LIMIT(10), .MODE(0)) u_wrap (
    .i_clk(clk), .i_rst(rst), .i_en(en[0]), .i_clr(clr[0]),
    .o_cnt(cnt[0]), .o_tick(tick[0]), .o_done(done[0]), .o_tick_any(tany[0]));
  multi_channel_step_counter #(.CHANNELS(CH), .WIDTH(W), .STEP(3), .LIMIT(10), .MODE(1)) u_sat (
    .i_clk(clk), .i_rst(rst), .i_en(en[1]), .i_clr(clr[1]),
    .o_cnt(cnt[1]), .o_tick(tick[1]), .o_done(done[1]), .o_tick_any(tany[1]));
  multi_channel_step_counter #(.CHANNELS(CH), .WIDTH(W), .STEP(3), .LIMIT(10), .MODE(2)) u_bnc (
    .i_clk(clk), .i_rst(rst), .i_en(en[2]), .i_clr(clr[2]),
    .o_cnt(cnt[2]), .o_tick(tick[2]), .o_done(done[2]), .o_tick_any(tany[2]));
  multi_channel_step_counter #(.CHANNELS(CH), .WIDTH(W), .STEP(200), .LIMIT(255), .MODE(0)) u_big (
    .i_clk(clk), .i_rst(rst), .i_en(en[3]), .i_clr(clr[3]),
    .o_cnt(cnt[3]), .o_tick(tick[3]), .o_done(done[3]), .o_tick_any(tany[3]));

  int p_step [ND] = '{3, 3, 3, 200};
  int p_lim  [ND] = '{10, 10, 10, 255};
  int p_mode [ND] = '{0, 1, 2, 0};

  int mc [ND][CH];
  int md [ND][CH];

  // cnt/tick/done of -1 means "not checked"; l == CH addresses o_tick_any.
  typedef struct {
    string tag;
    int    d;
    int    l;
    int    cnt;
    int    tick;
    int    done;
  } exp_t;
  exp_t sb[$];

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic push_exp(input string tag, input int d, input int l,
                          input int c, input int t, input int dn);
    exp_t e;
    e.tag = tag; e.d = d; e.l = l; e.cnt = c; e.tick = t; e.done = dn;
    sb.push_back(e);
  endtask

  task automatic model_push();
    int c, s, lim, t, anyt;
    for (int d = 0; d < ND; d++) begin
      anyt = 0;
      s    = p_step[d];
      lim  = p_lim[d];
      for (int l = 0; l < CH; l++) begin
        c = mc[d][l];
        t = 0;
        if (clr[d][l]) begin
          c = 0;
          md[d][l] = 0;
        end else if (en[d][l]) begin
          case (p_mode[d])
            0: begin
              if (c + s > lim) begin c = 0; t = 1; end
              else c = c + s;
            end
            1: begin
              if (c != lim) begin
                if (c + s >= lim) begin c = lim; t = 1; end
                else c = c + s;
              end
            end
            default: begin
              if (md[d][l] == 0) begin
                if (c + s >= lim) begin c = lim; md[d][l] = 1; t = 1; end
                else c = c + s;
              end else begin
                if (c <= s) begin c = 0; md[d][l] = 0; t = 1; end
                else c = c - s;
              end
            end
          endcase
        end
        mc[d][l] = c;
        anyt = anyt | t;
        push_exp("mdl", d, l, c, t, (p_mode[d] != 0 && c == lim) ? 1 : 0);
      end
      push_exp("mdl", d, CH, -1, anyt, -1);
    end
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.l == CH) begin
        check_val($sformatf("%s.u%0d.any", e.tag, e.d), int'(tany[e.d]), e.tick);
      end else begin
        if (e.cnt >= 0)
          check_val($sformatf("%s.u%0d.l%0d.cnt", e.tag, e.d, e.l),
                    int'(cnt[e.d][e.l*W +: W]), e.cnt);
        if (e.tick >= 0)
          check_val($sformatf("%s.u%0d.l%0d.tick", e.tag, e.d, e.l),
                    int'(tick[e.d][e.l]), e.tick);
        if (e.done >= 0)
          check_val($sformatf("%s.u%0d.l%0d.done", e.tag, e.d, e.l),
                    int'(done[e.d][e.l]), e.done);
      end
    end
  endtask

  // Called #1 after a rising edge with inputs already set for the next edge.
  task automatic cyc();
    model_push();
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic model_zero();
    for (int d = 0; d < ND; d++)
      for (int l = 0; l < CH; l++) begin
        mc[d][l] = 0;
        md[d][l] = 0;
      end
  endtask

  task automatic check_all_zero(input string tag);
    for (int d = 0; d < ND; d++) begin
      check_val($sformatf("%s.u%0d.cnt", tag, d), int'(cnt[d] != '0), 0);
      check_val($sformatf("%s.u%0d.tick", tag, d), int'(tick[d]), 0);
      check_val($sformatf("%s.u%0d.done", tag, d), int'(done[d]), 0);
      check_val($sformatf("%s.u%0d.any", tag, d), int'(tany[d]), 0);
    end
  endtask

  task automatic idle_inputs();
    for (int d = 0; d < ND; d++) begin
      en[d]  = '0;
      clr[d] = '0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    model_zero();
    rst = 1'b0;
  endtask

  int t_wrap [12] = '{3, 6, 9, 0, 3, 6, 9, 0, 3, 6, 9, 0};
  int k_wrap [12] = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1};
  int t_sat  [12] = '{3, 6, 9, 10, 10, 10, 10, 10, 10, 10, 10, 10};
  int k_sat  [12] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
  int t_bnc  [12] = '{3, 6, 9, 10, 7, 7, 7, 7, 4, 1, 0, 3};
  int k_bnc  [12] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0};
  int e_bnc  [12] = '{1, 1, 1, 1, 1, 0, 0, 0, 1, 1, 1, 1};
  int t_big  [12] = '{200, 0, 200, 0, 200, 0, 200, 0, 200, 0, 200, 0};
  int k_big  [12] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1};

  initial begin
    idle_inputs();
    do_reset();

    // Directed sequences on all four instances in parallel.
    for (int i = 0; i < 12; i++) begin
      en[0] = 4'b0001;
      en[1] = 4'b0010;
      en[2] = e_bnc[i] != 0 ? 4'b0100 : 4'b0000;
      en[3] = 4'b0001;
      push_exp("wrap", 0, 0, t_wrap[i], k_wrap[i], 0);
      push_exp("sat",  1, 1, t_sat[i],  k_sat[i],  t_sat[i] == 10 ? 1 : 0);
      push_exp("bnc",  2, 2, t_bnc[i],  k_bnc[i],  t_bnc[i] == 10 ? 1 : 0);
      push_exp("big",  3, 0, t_big[i],  k_big[i],  0);
      cyc();
    end

    // Clear beats enable on lane 3 while lane 0 keeps counting.
    do_reset();
    en[0] = 4'b1001;
    push_exp("clr_pre", 0, 3, 3, 0, 0);
    cyc();
    push_exp("clr_pre", 0, 3, 6, 0, 0);
    cyc();
    clr[0] = 4'b1000;
    push_exp("clr_en", 0, 3, 0, 0, 0);
    push_exp("clr_other", 0, 0, 9, 0, 0);
    cyc();
    clr[0] = 4'b0000;
    push_exp("clr_post", 0, 3, 3, 0, 0);
    cyc();
    push_exp("clr_post", 0, 3, 6, 0, 0);
    cyc();

    // Asynchronous reset between edges.
    #2 rst = 1'b1;
    #1 check_all_zero("async_rst");
    model_zero();
    #1 rst = 1'b0;
    push_exp("after_rst", 0, 3, 3, 0, 0);
    cyc();

    // Staggered lanes 0 and 2 for o_tick_any.
    do_reset();
    en[0] = 4'b0001;
    cyc();
    cyc();
    en[0] = 4'b0101;
    for (int i = 0; i < 12; i++) cyc();

    // Random enables and occasional clears on every instance.
    for (int i = 0; i < 300; i++) begin
      for (int d = 0; d < ND; d++) begin
        en[d]  = CH'($urandom_range(0, (1 << CH) - 1));
        clr[d] = ($urandom_range(0, 15) == 0) ? CH'($urandom_range(0, (1 << CH) - 1)) : '0;
      end
      cyc();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
